// File: rtl/vmem_pkg.sv
// Shared constants, types and the SRAM address packer for the framebuffer arbiter.
package vmem_pkg;
   localparam int H_W    = 10;
   localparam int V_W    = 9;
   localparam int DW     = 24;
   localparam int MEM_AW = 1 + V_W + H_W;

   typedef logic [DW-1:0] pixel_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } swap_state_t;

   function automatic logic [MEM_AW-1:0] pack_addr(
      input logic           buf_sel,
      input logic [V_W-1:0] v,
      input logic [H_W-1:0] h
   );
      return {buf_sel, v, h};
   endfunction
endpackage

// File: rtl/vmem_wr_fifo.sv
// Host write queue: synchronous FIFO with a registered occupancy count and
// power-of-two depth so the pointers wrap naturally.
module vmem_wr_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] store_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
   logic [PW:0]      count_r;
   logic             push_ok_s, pop_ok_s;

   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;
   assign full      = (count_r == (PW+1)'(DEPTH));
   assign empty     = (count_r == {(PW+1){1'b0}});
   assign dout      = store_r[rd_ptr_r];

   // Pointer and occupancy tracking.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         if (push_ok_s && !pop_ok_s) begin
            count_r <= count_r + (PW+1)'(1);
         end else if (!push_ok_s && pop_ok_s) begin
            count_r <= count_r - (PW+1)'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (push_ok_s) store_r[wr_ptr_r] <= din;
   end
endmodule

// File: rtl/vmem_arbiter.sv
// Framebuffer arbiter: scan-out reads own the SRAM whenever the pixel strobe lands in the
// visible area; queued host writes fill the remaining cycles, and buffer swaps wait for vblank.
module vmem_arbiter
   import vmem_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 pix_en,
   input  logic                 disp_valid,
   input  logic [H_W-1:0]       disp_h,
   input  logic [V_W-1:0]       disp_v,
   input  logic                 frame_start,
   output logic [DW-1:0]        disp_data,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [V_W+H_W-1:0]   wr_addr,
   input  logic [DW-1:0]        wr_data,
   input  logic                 swap_req,
   output logic                 swap_pending,
   output logic                 front_sel,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [MEM_AW-1:0]    mem_addr,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata
);
   localparam int WA = V_W + H_W;
   localparam int EW = WA + DW;

   swap_state_t       state_r, state_d;
   logic              front_sel_r;
   logic              fifo_full_s, fifo_empty_s, push_s, pop_s, read_slot_s, swap_now_s;
   logic [EW-1:0]     fifo_dout_s;
   logic              mem_en_d, mem_we_d, mem_en_r, mem_we_r;
   logic [MEM_AW-1:0] mem_addr_d, mem_addr_r;
   pixel_t            mem_wdata_d, mem_wdata_r, disp_data_r;
   logic              rd_slot1_r, rd_vis1_r, rd_slot2_r, rd_vis2_r;

   assign read_slot_s = pix_en && disp_valid;
   // Reset gates wr_ready directly so the host sees 0 the moment reset asserts.
   assign wr_ready    = reset && !fifo_full_s && (state_r == IDLE);
   assign push_s      = wr_valid && wr_ready;

   vmem_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({wr_addr, wr_data}),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Slot arbitration: display read first, otherwise the FIFO head into the back buffer.
   always_comb begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_r;
      mem_wdata_d = mem_wdata_r;
      pop_s       = 1'b0;
      if (read_slot_s) begin
         mem_en_d   = 1'b1;
         mem_addr_d = pack_addr(front_sel_r, disp_v, disp_h);
      end else if (!fifo_empty_s) begin
         mem_en_d    = 1'b1;
         mem_we_d    = 1'b1;
         pop_s       = 1'b1;
         mem_addr_d  = pack_addr(~front_sel_r, fifo_dout_s[EW-1 -: V_W], fifo_dout_s[DW +: H_W]);
         mem_wdata_d = fifo_dout_s[DW-1:0];
      end else begin
         mem_en_d = 1'b0;
      end
   end

   // Registered SRAM interface.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {MEM_AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
      end else begin
         mem_en_r    <= mem_en_d;
         mem_we_r    <= mem_we_d;
         mem_addr_r  <= mem_addr_d;
         mem_wdata_r <= mem_wdata_d;
      end
   end

   // Two-stage slot tracker lining up each pixel strobe with the SRAM read latency.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_slot1_r  <= 1'b0;
         rd_vis1_r   <= 1'b0;
         rd_slot2_r  <= 1'b0;
         rd_vis2_r   <= 1'b0;
         disp_data_r <= {DW{1'b0}};
      end else begin
         rd_slot1_r <= pix_en;
         rd_vis1_r  <= read_slot_s;
         rd_slot2_r <= rd_slot1_r;
         rd_vis2_r  <= rd_vis1_r;
         if (rd_slot2_r) begin
            disp_data_r <= rd_vis2_r ? mem_rdata : {DW{1'b0}};
         end
      end
   end

   // Swap FSM next state.
   always_comb begin
      state_d    = state_r;
      swap_now_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (swap_req) state_d = PENDING;
            else          state_d = IDLE;
         end
         PENDING: begin
            // mem_we_r flags a write popped last cycle that the SRAM is only now performing.
            if (frame_start && fifo_empty_s && !pop_s && !mem_we_r) begin
               state_d    = IDLE;
               swap_now_s = 1'b1;
            end else begin
               state_d = PENDING;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Swap FSM state and front-buffer select.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         front_sel_r <= 1'b0;
      end else begin
         state_r <= state_d;
         if (swap_now_s) front_sel_r <= ~front_sel_r;
      end
   end

   assign disp_data    = disp_data_r;
   assign swap_pending = (state_r == PENDING);
   assign front_sel    = front_sel_r;
   assign mem_en       = mem_en_r;
   assign mem_we       = mem_we_r;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;
endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: randomized scan/host traffic against a behavioural SRAM
// and a slot/ordering model derived from the arbitration and swap rules.
module tb_vmem_arbiter;
   import vmem_pkg::*;
   localparam int WA = V_W + H_W;

   logic              clock, reset, pix_en, disp_valid, frame_start;
   logic              wr_valid, wr_ready, swap_req, swap_pending, front_sel, mem_en, mem_we;
   logic [H_W-1:0]    disp_h;
   logic [V_W-1:0]    disp_v;
   logic [WA-1:0]     wr_addr;
   logic [MEM_AW-1:0] mem_addr;
   pixel_t            disp_data, wr_data, mem_wdata;
   pixel_t            mem_rdata = '0;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic f_model  = 1'b0;

   typedef struct {
      logic [MEM_AW-1:0] addr;
      pixel_t            data;
      logic              we;
      int                cyc;
   } acc_t;

   pixel_t preload [logic [MEM_AW-1:0]];
   acc_t   alog [$];

   vmem_arbiter #(.FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .pix_en(pix_en), .disp_valid(disp_valid),
      .disp_h(disp_h), .disp_v(disp_v), .frame_start(frame_start), .disp_data(disp_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .swap_req(swap_req), .swap_pending(swap_pending), .front_sel(front_sel),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic pixel_t ref_pix(input logic [MEM_AW-1:0] a);
      if (preload.exists(a)) return preload[a];
      return {4'h5, a};
   endfunction

   // Behavioural SRAM: 1-cycle read latency, logs every access with its edge index.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_en === 1'b1) begin
         alog.push_back('{addr: mem_addr, data: mem_wdata, we: mem_we, cyc: cyc});
         if (mem_we !== 1'b1) mem_rdata <= ref_pix(mem_addr);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      pix_en = 1'b0; disp_valid = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
      wr_valid = 1'b0; disp_h = '0; disp_v = '0; wr_addr = '0; wr_data = '0;
   endtask

   task automatic collect_writes(output acc_t w [$]);
      w = {};
      foreach (alog[i]) if (alog[i].we) w.push_back(alog[i]);
   endtask

   task automatic test_reset();
      idle_inputs();
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = WA'($urandom); wr_data = DW'($urandom) | 24'h000001;
         tick();
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b00, {MEM_AW{1'b0}}, {DW{1'b0}}}) begin
         failures++;
         $display("FAIL reset_mem: got en=%b we=%b addr=%h wdata=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if ({disp_data, front_sel, swap_pending, wr_ready} !== {{DW{1'b0}}, 3'b000}) begin
         failures++;
         $display("FAIL reset_out: got disp=%h front=%b pend=%b rdy=%b expected all 0", disp_data, front_sel, swap_pending, wr_ready);
      end
      wr_valid = 1'b0;
      tick();
      #2 reset = 1'b1;
      tick();
      f_model = 1'b0;
      checks++;
      if ({wr_ready, front_sel, swap_pending, mem_en} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_release: got rdy=%b front=%b pend=%b en=%b expected 1 0 0 0", wr_ready, front_sel, swap_pending, mem_en);
      end
      alog.delete();
   endtask

   task automatic test_read_latency();
      pixel_t exp_d [20];
      logic   vis [20];
      logic [V_W-1:0] vv;
      logic [H_W-1:0] hh;
      preload[pack_addr(1'b0, 9'd5, 10'd7)] = 24'hABCDEF;
      idle_inputs();
      pix_en = 1'b1; disp_valid = 1'b1; disp_v = 9'd5; disp_h = 10'd7;
      tick();
      idle_inputs();
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 20'h01407}) begin
         failures++;
         $display("FAIL t2_addr: got en=%b we=%b addr=%h expected 1 0 01407", mem_en, mem_we, mem_addr);
      end
      tick();
      checks++;
      if (disp_data !== 24'h000000) begin
         failures++;
         $display("FAIL t2_early: got %h expected 000000", disp_data);
      end
      tick();
      checks++;
      if (disp_data !== 24'hABCDEF) begin
         failures++;
         $display("FAIL t2_data: got %h expected abcdef", disp_data);
      end
      // Back-to-back strobes with random visibility.
      for (int i = 0; i < 20; i++) begin
         if (i < 18) begin
            vv = V_W'($urandom_range(0, 479)); hh = H_W'($urandom_range(0, 639));
            vis[i] = 1'($urandom_range(0, 3) != 0);
            pix_en = 1'b1; disp_valid = vis[i]; disp_v = vv; disp_h = hh;
            exp_d[i] = vis[i] ? ref_pix({f_model, vv, hh}) : {DW{1'b0}};
         end else begin
            idle_inputs();
         end
         tick();
         if (i < 18) begin
            checks++;
            if (mem_en !== vis[i]) begin
               failures++;
               $display("FAIL rd_en[%0d]: got %b expected %b", i, mem_en, vis[i]);
            end
         end
         if (i >= 2) begin
            checks++;
            if (disp_data !== exp_d[i-2]) begin
               failures++;
               $display("FAIL rd_data[%0d]: got %h expected %h", i - 2, disp_data, exp_d[i-2]);
            end
         end
      end
   endtask

   task automatic test_arbitration();
      logic [WA-1:0]     wa [8];
      pixel_t            wd [8];
      int                acc_c [8];
      bit                pix_at [int];
      logic [MEM_AW-1:0] rexp [$];
      acc_t              w [$];
      int                n = 0;
      int                nr = 0;
      bit                ok;
      for (int j = 0; j < 8; j++) begin
         wa[j] = WA'($urandom); wd[j] = DW'($urandom);
      end
      idle_inputs();
      alog.delete();
      for (int k = 0; k < 40; k++) begin
         pix_en = (k % 2 == 0); disp_valid = 1'b1;
         disp_v = V_W'($urandom_range(0, 479)); disp_h = H_W'($urandom_range(0, 639));
         pix_at[cyc] = pix_en;
         if (pix_en) rexp.push_back({f_model, disp_v, disp_h});
         wr_valid = (n < 8);
         if (n < 8) begin
            wr_addr = wa[n]; wr_data = wd[n];
         end
         ok = wr_valid && wr_ready;
         if (ok) acc_c[n] = cyc;
         tick();
         if (ok) n++;
      end
      idle_inputs();
      repeat (3) tick();
      checks++;
      if (n !== 8) begin
         failures++;
         $display("FAIL t3_accepted: got %0d expected 8", n);
      end
      collect_writes(w);
      checks++;
      if (w.size() !== 8) begin
         failures++;
         $display("FAIL t3_wr_count: got %0d expected 8", w.size());
      end
      for (int j = 0; j < 8 && j < w.size(); j++) begin
         checks++;
         if ({w[j].addr, w[j].data} !== {~f_model, wa[j], wd[j]} || w[j].cyc < acc_c[j] + 2 ||
             (pix_at.exists(w[j].cyc - 1) && pix_at[w[j].cyc - 1])) begin
            failures++;
            $display("FAIL t3_wr[%0d]: got addr=%h data=%h edge=%0d expected addr=%h data=%h edge>=%0d in a non-strobe slot",
                     j, w[j].addr, w[j].data, w[j].cyc, {~f_model, wa[j]}, wd[j], acc_c[j] + 2);
         end
      end
      foreach (alog[i]) begin
         if (!alog[i].we) begin
            checks++;
            if (nr >= rexp.size() || alog[i].addr !== rexp[nr]) begin
               failures++;
               $display("FAIL t3_rd[%0d]: got %h expected %h", nr, alog[i].addr, (nr < rexp.size()) ? rexp[nr] : '0);
            end
            nr++;
         end
      end
      checks++;
      if (nr !== rexp.size()) begin
         failures++;
         $display("FAIL t3_rd_count: got %0d expected %0d", nr, rexp.size());
      end
   endtask

   task automatic test_full_fifo();
      logic [WA-1:0] wa [5];
      pixel_t        wd [5];
      acc_t          w [$];
      int            n = 0;
      bit            ok;
      for (int j = 0; j < 5; j++) begin
         wa[j] = WA'($urandom); wd[j] = DW'($urandom);
      end
      idle_inputs();
      alog.delete();
      pix_en = 1'b1; disp_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wr_valid = 1'b1; wr_addr = wa[n]; wr_data = wd[n];
         ok = wr_ready;
         tick();
         if (ok) n++;
      end
      collect_writes(w);
      checks++;
      if (n !== 4 || wr_ready !== 1'b0 || w.size() !== 0) begin
         failures++;
         $display("FAIL t4_full: got accepted=%0d rdy=%b writes=%0d expected 4 0 0", n, wr_ready, w.size());
      end
      disp_valid = 1'b0;
      for (int k = 0; k < 12 && n < 5; k++) begin
         wr_addr = wa[n]; wr_data = wd[n];
         ok = wr_ready;
         tick();
         if (ok) n++;
      end
      checks++;
      if (n !== 5) begin
         failures++;
         $display("FAIL t4_drain_timeout: got accepted=%0d expected 5", n);
      end
      idle_inputs();
      repeat (6) tick();
      collect_writes(w);
      checks++;
      if (w.size() !== 5 || wr_ready !== 1'b1) begin
         failures++;
         $display("FAIL t4_wr_count: got writes=%0d rdy=%b expected 5 1", w.size(), wr_ready);
      end
      for (int j = 0; j < 5 && j < w.size(); j++) begin
         checks++;
         if ({w[j].addr, w[j].data} !== {~f_model, wa[j], wd[j]}) begin
            failures++;
            $display("FAIL t4_wr[%0d]: got %h/%h expected %h/%h", j, w[j].addr, w[j].data, {~f_model, wa[j]}, wd[j]);
         end
      end
   endtask

   task automatic test_swap_deferral();
      acc_t w [$];
      int   n = 0;
      logic old_f;
      idle_inputs();
      alog.delete();
      old_f = f_model;
      pix_en = 1'b1; disp_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wr_valid = (n < 3); wr_addr = WA'($urandom); wr_data = DW'($urandom);
         if (wr_valid && wr_ready) n++;
         tick();
      end
      wr_valid = 1'b0;
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++;
      if ({front_sel, swap_pending, wr_ready} !== {old_f, 2'b10} || n !== 3) begin
         failures++;
         $display("FAIL t5_defer: got front=%b pend=%b rdy=%b queued=%0d expected %b 1 0 3", front_sel, swap_pending, wr_ready, n, old_f);
      end
      pix_en = 1'b0; disp_valid = 1'b0;
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      repeat (6) tick();
      checks++;
      if ({front_sel, swap_pending} !== {old_f, 1'b1}) begin
         failures++;
         $display("FAIL t5_hold: got front=%b pend=%b expected %b 1", front_sel, swap_pending, old_f);
      end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      f_model = ~f_model;
      checks++;
      if ({front_sel, swap_pending, wr_ready} !== {f_model, 2'b01}) begin
         failures++;
         $display("FAIL t5_swap: got front=%b pend=%b rdy=%b expected %b 0 1", front_sel, swap_pending, wr_ready, f_model);
      end
      collect_writes(w);
      checks++;
      if (w.size() !== 3 || w[0].addr[MEM_AW-1] !== f_model || w[2].addr[MEM_AW-1] !== f_model) begin
         failures++;
         $display("FAIL t5_backbuf: got writes=%0d expected 3 into buffer %b", w.size(), f_model);
      end
      tick();
      checks++;
      if (swap_pending !== 1'b0) begin
         failures++;
         $display("FAIL t5_ignored_req: got pend=%b expected 0", swap_pending);
      end
      // A write still in flight at frame_start blocks the swap.
      pix_en = 1'b1; disp_valid = 1'b1;
      wr_valid = 1'b1; wr_addr = WA'($urandom); wr_data = DW'($urandom);
      tick();
      wr_valid = 1'b0; swap_req = 1'b1; tick(); swap_req = 1'b0;
      pix_en = 1'b0; disp_valid = 1'b0;
      tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      checks++;
      if ({front_sel, swap_pending} !== {f_model, 1'b1}) begin
         failures++;
         $display("FAIL t5_inflight: got front=%b pend=%b expected %b 1", front_sel, swap_pending, f_model);
      end
      tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      f_model = ~f_model;
      checks++;
      if ({front_sel, swap_pending} !== {f_model, 1'b0}) begin
         failures++;
         $display("FAIL t5_late_swap: got front=%b pend=%b expected %b 0", front_sel, swap_pending, f_model);
      end
      // swap_req coinciding with frame_start only arms the swap.
      swap_req = 1'b1; frame_start = 1'b1; tick(); swap_req = 1'b0; frame_start = 1'b0;
      checks++;
      if ({front_sel, swap_pending} !== {f_model, 1'b1}) begin
         failures++;
         $display("FAIL t5_same_cycle: got front=%b pend=%b expected %b 1", front_sel, swap_pending, f_model);
      end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      f_model = ~f_model;
      checks++;
      if ({front_sel, swap_pending} !== {f_model, 1'b0}) begin
         failures++;
         $display("FAIL t5_next_frame: got front=%b pend=%b expected %b 0", front_sel, swap_pending, f_model);
      end
   endtask

   task automatic test_blanking();
      logic [V_W-1:0] vv;
      logic [H_W-1:0] hh;
      pixel_t         first;
      idle_inputs();
      vv = V_W'($urandom_range(0, 479)); hh = H_W'($urandom_range(0, 639));
      first = ref_pix({f_model, vv, hh});
      pix_en = 1'b1; disp_valid = 1'b1; disp_v = vv; disp_h = hh;
      tick();
      disp_valid = 1'b0;
      tick();
      pix_en = 1'b0;
      checks++;
      if (mem_en !== 1'b0) begin
         failures++;
         $display("FAIL t6_no_access: got en=%b expected 0", mem_en);
      end
      tick();
      checks++;
      if (disp_data !== first) begin
         failures++;
         $display("FAIL t6_visible: got %h expected %h", disp_data, first);
      end
      tick();
      checks++;
      if (disp_data !== {DW{1'b0}}) begin
         failures++;
         $display("FAIL t6_blank: got %h expected 000000", disp_data);
      end
      tick();
      checks++;
      if (disp_data !== {DW{1'b0}}) begin
         failures++;
         $display("FAIL t6_hold: got %h expected 000000", disp_data);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      #2 reset = 1'b1;
      tick();
      test_reset();
      test_read_latency();
      test_arbitration();
      test_full_fifo();
      test_swap_deferral();
      test_blanking();
      test_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
